// File: rtl/ps2_dev_pkg.sv
// Shared definitions for the PS/2 device-side transmitter: frame state encoding
// and the helper that decides which states a host inhibit may abort.
package ps2_dev_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_DATA0  = 4'd1,
        ST_DATA1  = 4'd2,
        ST_DATA2  = 4'd3,
        ST_DATA3  = 4'd4,
        ST_DATA4  = 4'd5,
        ST_DATA5  = 4'd6,
        ST_DATA6  = 4'd7,
        ST_DATA7  = 4'd8,
        ST_PARITY = 4'd9,
        ST_STOP   = 4'd10,
        ST_TRAIL  = 4'd11
    } ps2_state_e;

    localparam int FRAME_TICKS = 12;

    // Once STOP is reached the byte is committed, so only earlier states abort.
    function automatic logic abortable(input ps2_state_e st);
        return (st >= ST_DATA0) && (st <= ST_PARITY);
    endfunction

endpackage

// File: rtl/ps2_dev_chan.sv
// One PS/2 device channel: byte FIFO plus frame serialiser with host-inhibit
// abort. The head byte is popped only at STOP so an aborted frame is resent.
module ps2_dev_chan
    import ps2_dev_pkg::*;
#(
    parameter int FIFO_BITS = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       tick,
    input  logic       clk_ps2,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic       ps2_clk_in,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow,
    output logic       busy
);

    localparam int DEPTH = 1 << FIFO_BITS;

    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_BITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_BITS:0]   occ_q, occ_d;
    logic                 ovf_q, ovf_d;
    ps2_state_e           state_q, state_d;
    logic [7:0]           sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 data_q, data_d;
    logic                 push, pop, full, empty;

    assign full  = occ_q[FIFO_BITS];
    assign empty = (occ_q == '0);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        par_d   = par_q;
        data_d  = data_q;
        pop     = 1'b0;
        // Line held low while we are releasing it: the host wants the bus back.
        if (clk_ps2 && !ps2_clk_in && abortable(state_q)) begin
            state_d = ST_IDLE;
            data_d  = 1'b1;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty && ps2_clk_in) begin
                        sh_d    = mem_q[rptr_q];
                        par_d   = 1'b1;
                        data_d  = 1'b0;
                        state_d = ST_DATA0;
                    end
                end
                ST_PARITY: begin
                    data_d  = par_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    data_d  = 1'b1;
                    pop     = 1'b1;
                    state_d = ST_TRAIL;
                end
                ST_TRAIL: state_d = ST_IDLE;
                default: begin
                    data_d  = sh_q[0];
                    par_d   = par_q ^ sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                    state_d = ps2_state_e'(state_q + 4'd1);
                end
            endcase
        end
    end

    always_comb begin
        push   = wr && (!full || pop);
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        ovf_d  = ovf_q | (wr && !push);
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            par_q   <= 1'b0;
            data_q  <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            data_q  <= data_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    assign ps2_clk    = clk_ps2 | (state_q == ST_IDLE);
    assign ps2_data   = data_q;
    assign fifo_full  = full;
    assign fifo_empty = empty;
    assign overflow   = ovf_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: rtl/ps2_dev_tx.sv
// N-channel PS/2 device transmitter: one shared PS/2 clock divider feeding
// NCH independent channels, so every channel's frames are tick-aligned.
module ps2_dev_tx
    import ps2_dev_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 100
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [NCH-1:0]   in_wr,
    input  logic [8*NCH-1:0] in_data,
    input  logic [NCH-1:0]   ps2_clk_in,
    output logic [NCH-1:0]   ps2_clk,
    output logic [NCH-1:0]   ps2_data,
    output logic [NCH-1:0]   fifo_full,
    output logic [NCH-1:0]   fifo_empty,
    output logic [NCH-1:0]   overflow,
    output logic [NCH-1:0]   busy
);

    localparam int CNT_W = (PS2DIV < 1) ? 1 : $clog2(PS2DIV + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_ps2_q, clk_ps2_d;
    logic             tick_q, tick_d;

    // clk_ps2 idles high so the first rising edge lands a full period after reset.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        clk_ps2_d = clk_ps2_q;
        tick_d    = 1'b0;
        if (cnt_q == CNT_W'(PS2DIV)) begin
            cnt_d     = '0;
            clk_ps2_d = ~clk_ps2_q;
            tick_d    = ~clk_ps2_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q     <= '0;
            clk_ps2_q <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_ps2_q <= clk_ps2_d;
            tick_q    <= tick_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ps2_dev_chan #(
            .FIFO_BITS (FIFO_BITS)
        ) u_chan (
            .clk_sys    (clk_sys),
            .reset      (reset),
            .tick       (tick_q),
            .clk_ps2    (clk_ps2_q),
            .wr         (in_wr[i]),
            .wdata      (in_data[8*i +: 8]),
            .ps2_clk_in (ps2_clk_in[i]),
            .ps2_clk    (ps2_clk[i]),
            .ps2_data   (ps2_data[i]),
            .fifo_full  (fifo_full[i]),
            .fifo_empty (fifo_empty[i]),
            .overflow   (overflow[i]),
            .busy       (busy[i])
        );
    end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Directed bench for ps2_dev_tx: frame contents, FIFO overflow, host inhibit,
// abort/retransmit and mid-frame reset, with PS2DIV=3 (8-cycle PS/2 period).
module tb_ps2_dev_tx;

    localparam int NCH = 2;
    localparam int FB  = 3;
    localparam int DIV = 3;
    localparam int P   = 2 * (DIV + 1);

    logic             clk_sys = 1'b0;
    logic             reset   = 1'b1;
    logic [NCH-1:0]   in_wr   = '0;
    logic [8*NCH-1:0] in_data = '0;
    logic [NCH-1:0]   ps2_clk_in = '1;
    logic [NCH-1:0]   ps2_clk, ps2_data, fifo_full, fifo_empty, overflow, busy;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    ps2_dev_tx #(.NCH(NCH), .FIFO_BITS(FB), .PS2DIV(DIV)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .in_wr      (in_wr),
        .in_data    (in_data),
        .ps2_clk_in (ps2_clk_in),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Edges since reset release; channel state moves on edges k*P+1 (k>=1).
    always @(posedge clk_sys) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_upd();
        do @(negedge clk_sys); while (!((cyc % P) == 1 && cyc > P));
    endtask

    task automatic wr_byte(input int ch, input logic [7:0] b);
        in_wr[ch] = 1'b1;
        in_data[8*ch +: 8] = b;
        @(negedge clk_sys);
        in_wr[ch] = 1'b0;
    endtask

    // Steps 1..11 carry start, 8 data bits LSB first, odd parity, stop; step 12 is idle.
    task automatic check_frame(input int ch, input logic [7:0] b, input int nsteps, input logic last);
        logic [10:0] exp_bits;
        int oc;
        oc = 1 - ch;
        exp_bits = {1'b1, ~^b, b, 1'b0};
        for (int k = 1; k <= nsteps; k++) begin
            wait_upd();
            if (k <= 11) begin
                chk($sformatf("data ch%0d %02h t%0d", ch, b, k), 32'(ps2_data[ch]), 32'(exp_bits[k-1]));
                chk($sformatf("busy ch%0d t%0d", ch, k), 32'(busy[ch]), 32'd1);
                chk($sformatf("clk_hi ch%0d t%0d", ch, k), 32'(ps2_clk[ch]), 32'd1);
                chk($sformatf("empty ch%0d t%0d", ch, k), 32'(fifo_empty[ch]), (k == 11) ? 32'(last) : 32'd0);
                if (k < nsteps) begin
                    repeat (4) @(negedge clk_sys);
                    chk($sformatf("clk_lo ch%0d t%0d", ch, k), 32'(ps2_clk[ch]), 32'd0);
                    chk($sformatf("other_idle ch%0d t%0d", oc, k), 32'({ps2_clk[oc], ps2_data[oc]}), 32'b11);
                end
            end else begin
                chk($sformatf("end_busy ch%0d", ch), 32'(busy[ch]), 32'd0);
                chk($sformatf("end_data ch%0d", ch), 32'(ps2_data[ch]), 32'd1);
                chk($sformatf("end_clk ch%0d", ch), 32'(ps2_clk[ch]), 32'd1);
            end
        end
    endtask

    function automatic logic [7:0] burst_byte(input int i);
        return 8'(8'h3A + i * 29);
    endfunction

    initial begin
        repeat (3) @(negedge clk_sys);
        chk("rst_data",  32'(ps2_data),   32'b11);
        chk("rst_clk",   32'(ps2_clk),    32'b11);
        chk("rst_ovf",   32'(overflow),   32'b00);
        chk("rst_full",  32'(fifo_full),  32'b00);
        chk("rst_empty", 32'(fifo_empty), 32'b11);
        chk("rst_busy",  32'(busy),       32'b00);

        // Single byte, then two back-to-back parity corner cases.
        reset = 1'b0;
        wr_byte(0, 8'h1C);
        check_frame(0, 8'h1C, 12, 1'b1);
        wr_byte(0, 8'h00);
        wr_byte(0, 8'hFF);
        check_frame(0, 8'h00, 12, 1'b0);
        check_frame(0, 8'hFF, 12, 1'b1);

        // Burst of 9 while the host inhibits: 8 fit, the 9th is dropped.
        ps2_clk_in[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_byte(0, burst_byte(i));
            chk($sformatf("burst_full %0d", i), 32'(fifo_full[0]), (i >= 7) ? 32'd1 : 32'd0);
            chk($sformatf("burst_ovf %0d", i), 32'(overflow[0]), (i == 8) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            wait_upd();
            chk("inhibit_busy", 32'(busy[0]), 32'd0);
            chk("inhibit_data", 32'(ps2_data[0]), 32'd1);
        end
        ps2_clk_in[0] = 1'b1;
        for (int i = 0; i < 8; i++) check_frame(0, burst_byte(i), 12, (i == 7));
        wait_upd();
        chk("burst_done_busy",  32'(busy[0]),       32'd0);
        chk("burst_done_empty", 32'(fifo_empty[0]), 32'd1);
        chk("ovf_sticky",       32'(overflow[0]),   32'd1);

        // Abort during DATA3 of 0xA5, then a single complete resend.
        wr_byte(0, 8'hA5);
        check_frame(0, 8'hA5, 4, 1'b0);
        ps2_clk_in[0] = 1'b0;
        @(negedge clk_sys);
        chk("abort_busy",  32'(busy[0]),       32'd0);
        chk("abort_data",  32'(ps2_data[0]),   32'd1);
        chk("abort_clk",   32'(ps2_clk[0]),    32'd1);
        chk("abort_empty", 32'(fifo_empty[0]), 32'd0);
        wait_upd();
        chk("abort_hold_busy", 32'(busy[0]), 32'd0);
        ps2_clk_in[0] = 1'b1;
        check_frame(0, 8'hA5, 12, 1'b1);
        wait_upd();
        chk("resend_once_busy", 32'(busy[0]),       32'd0);
        chk("resend_empty",     32'(fifo_empty[0]), 32'd1);

        // Reset while ch1 sits in PARITY with more bytes queued.
        wr_byte(1, 8'h96);
        wr_byte(1, 8'h3C);
        wr_byte(1, 8'hE1);
        check_frame(1, 8'h96, 9, 1'b0);
        chk("ovf_before_rst", 32'(overflow[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("mrst_data",  32'(ps2_data),   32'b11);
        chk("mrst_clk",   32'(ps2_clk),    32'b11);
        chk("mrst_empty", 32'(fifo_empty), 32'b11);
        chk("mrst_busy",  32'(busy),       32'b00);
        chk("mrst_ovf",   32'(overflow),   32'b00);
        chk("mrst_full",  32'(fifo_full),  32'b00);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_upd();
            chk("post_rst_busy", 32'(busy),     32'b00);
            chk("post_rst_data", 32'(ps2_data), 32'b11);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
